regfile_write_ctrl: RTL and testbench
=====================================

REGFILE_WRITE_CTRL -- requirements
Module: regfile_write_ctrl

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1, meaning 1 = zero registers 1..31 after reset, 0 = skip clear.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_valid  input  1  ALU writeback request.
REQ-005 a_ready  output  1  ALU request accepted this cycle when a_valid & a_ready.
REQ-006 a_addr  input  5  ALU destination register.
REQ-007 a_data  input  32  ALU write data.
REQ-008 m_valid / m_ready / m_addr / m_data  in / out / in / in  1 / 1 / 5 / 32  load writeback request, same meaning as ALU port.
REQ-009 wren  output  1  regfile write enable.
REQ-010 wr  output  5  regfile write address.
REQ-011 wd  output  32  regfile write data.
REQ-012 init_done  output  1  high once clear sequence finished; stays high until reset.
REQ-013 q1_addr, q2_addr  input  5 each  regfile read addresses under query.
REQ-014 q1_hit, q2_hit  output  1 each  pending-write bypass indication per query.

Function
REQ-015 Two states: CLEAR, RUN; 5-bit clear counter cnt; 1-bit round-robin pointer prio (0 = ALU, 1 = load).
REQ-016 wren, wr, wd, init_done, cnt, prio and state are registers; a_ready, m_ready, q1_hit, q2_hit are combinational.
REQ-017 CLEAR (CLEAR_ON_RESET=1): each cycle wren=1, wr=cnt, wd=0, cnt increments; after the cycle writing wr=31, state goes to RUN and init_done=1.
REQ-018 CLEAR spans exactly 31 cycles of wren=1 (wr 1..31 in order); wr=0 is never written.
REQ-019 CLEAR_ON_RESET=0: reset leaves state RUN; init_done=1 on first posedge after reset deasserts.
REQ-020 In CLEAR: a_ready=m_ready=0.
REQ-021 In RUN: a_ready = a_valid & (!m_valid | prio==0); m_ready = m_valid & (!a_valid | prio==1); never both high.
REQ-022 Readies depend on valids and prio only; valids need not depend on ready.
REQ-023 Grant to one port toggles prio to the other port; no grant leaves prio unchanged.
REQ-024 Accepted request appears on wr/wd at next posedge (latency 1); wren=1 that cycle unless addr==0.
REQ-025 Accepted request with addr==0: handshake completes, wren=0, wr/wd hold previous values.
REQ-026 No grant in a cycle: wren=0 next cycle; wr/wd hold.
REQ-027 Throughput: one write per cycle, back-to-back grants allowed, no bubbles.
REQ-028 qN_hit = wren & (wr==qN_addr) & (qN_addr!=0); consumer bypasses with wd.
REQ-029 During CLEAR qN_hit follows REQ-028 (wd=0, consistent).
REQ-030 No overflow/underflow: cnt stops at 31 on CLEAR exit; no buffering beyond the single output register.

Reset
REQ-031 rst assertion, at any time including mid-CLEAR or mid-handshake, immediately forces wren=0, wr=0, wd=0, init_done=0, prio=0, cnt=1, state=CLEAR (or RUN if CLEAR_ON_RESET=0).
REQ-032 Request in flight at reset assertion is dropped; no write is issued for it.
REQ-033 After rst deasserts, first clear write (wr=1) occurs at the first posedge.

Verification
REQ-034 Reset release, no requests -> wren=1 for 31 cycles, wr 1..31, wd=0; init_done=1 from cycle 32; then wren=0.
REQ-035 RUN, a_valid only, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle wren=1, wr=5, wd=0xDEADBEEF, q1_hit=1 for q1_addr=5.
REQ-036 RUN, both valid for 4 cycles, prio=0 -> grants A,M,A,M; wr/wd follow that order one cycle later; ready never both high.
REQ-037 RUN, m_valid with m_addr=0, m_data=0x1234 -> m_ready=1; next cycle wren=0; q1_hit=0 for q1_addr=0.
REQ-038 rst pulsed at clear cycle 10 -> outputs zero immediately; after release wr restarts at 1 with 31 clear writes.
REQ-039 CLEAR_ON_RESET=0, a_valid held from reset release -> a_ready=1 on first cycle after release; write lands next cycle.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl
//
// Write-port controller for a 32 x 32-bit register file. After reset it can
// sweep registers 1..31 to zero. It then arbitrates between an ALU writeback
// port and a load writeback port, using a round-robin pointer, and produces
// one registered write per cycle.
//
// Parameters
//   CLEAR_ON_RESET  1: zero registers 1..31 after reset; 0: start in RUN.
//
// Ports
//   clk_i, rst_i             clock; asynchronous active-high reset
//   a_valid_i / a_ready_o    ALU writeback handshake
//   a_addr_i, a_data_i       ALU destination register and data
//   m_valid_i / m_ready_o    load writeback handshake
//   m_addr_i, m_data_i       load destination register and data
//   wren_o, wr_o, wd_o       registered regfile write enable / address / data
//   init_done_o              high once the clear sweep has finished
//   q1_addr_i, q2_addr_i     read addresses under query
//   q1_hit_o, q2_hit_o       the queried register is being written this cycle

module regfile_write_ctrl #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [4:0]  a_addr_i,
    input  logic [31:0] a_data_i,

    input  logic        m_valid_i,
    output logic        m_ready_o,
    input  logic [4:0]  m_addr_i,
    input  logic [31:0] m_data_i,

    output logic        wren_o,
    output logic [4:0]  wr_o,
    output logic [31:0] wd_o,
    output logic        init_done_o,

    input  logic [4:0]  q1_addr_i,
    input  logic [4:0]  q2_addr_i,
    output logic        q1_hit_o,
    output logic        q2_hit_o
);

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StRun;
    localparam logic [4:0] LastReg = 5'd31;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic        wren_q, wren_d;
    logic [4:0]  wr_q, wr_d;
    logic [31:0] wd_q, wd_d;
    logic        init_done_q, init_done_d;

    logic        grant_a;
    logic        grant_m;
    logic        clear_last;

    // Round-robin arbitration. prio_q names the port that wins a tie.
    // Neither port can be granted while the clear sweep owns the write port.
    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (state_q == StRun) begin
            grant_a = a_valid_i & (~m_valid_i | ~prio_q);
            grant_m = m_valid_i & (~a_valid_i |  prio_q);
        end
    end

    assign a_ready_o = grant_a;
    assign m_ready_o = grant_m;

    // The sweep ends one cycle after register 31 is written. That keeps
    // wr=31 visible for a full cycle before RUN begins.
    assign clear_last = wren_q & (wr_q == LastReg);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        wren_d      = 1'b0;
        wr_d        = wr_q;
        wd_d        = wd_q;
        init_done_d = init_done_q;

        unique case (state_q)
            StClear: begin
                if (clear_last) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end else begin
                    wren_d = 1'b1;
                    wr_d   = cnt_q;
                    wd_d   = 32'd0;
                    // Saturate at 31: the counter does not wrap back to 0.
                    if (cnt_q != LastReg) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StRun: begin
                init_done_d = 1'b1;
                if (grant_a) begin
                    prio_d = 1'b1;
                    // Writes to x0 complete the handshake but are discarded.
                    if (a_addr_i != 5'd0) begin
                        wren_d = 1'b1;
                        wr_d   = a_addr_i;
                        wd_d   = a_data_i;
                    end
                end else if (grant_m) begin
                    prio_d = 1'b0;
                    if (m_addr_i != 5'd0) begin
                        wren_d = 1'b1;
                        wr_d   = m_addr_i;
                        wd_d   = m_data_i;
                    end
                end
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ResetState;
            cnt_q       <= 5'd1;
            prio_q      <= 1'b0;
            wren_q      <= 1'b0;
            wr_q        <= 5'd0;
            wd_q        <= 32'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            wren_q      <= wren_d;
            wr_q        <= wr_d;
            wd_q        <= wd_d;
            init_done_q <= init_done_d;
        end
    end

    assign wren_o      = wren_q;
    assign wr_o        = wr_q;
    assign wd_o        = wd_q;
    assign init_done_o = init_done_q;

    // A register being written this cycle can be forwarded from wd_o.
    // x0 never hits.
    assign q1_hit_o = wren_q & (wr_q == q1_addr_i) & (q1_addr_i != 5'd0);
    assign q2_hit_o = wren_q & (wr_q == q2_addr_i) & (q2_addr_i != 5'd0);

    always_comb begin
        assert (!(a_ready_o && m_ready_o));
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed testbench for regfile_write_ctrl. dut0 uses the clear sweep,
// dut1 starts directly in RUN. Both instances share the stimulus.

module tb_regfile_write_ctrl;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;

    logic        a_ready0, m_ready0, wren0, init_done0, q1_hit0, q2_hit0;
    logic [4:0]  wr0;
    logic [31:0] wd0;
    logic        a_ready1, m_ready1, wren1, init_done1, q1_hit1, q2_hit1;
    logic [4:0]  wr1;
    logic [31:0] wd1;

    int tests;
    int fails;

    regfile_write_ctrl #(.CLEAR_ON_RESET(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready0), .a_addr_i(a_addr), .a_data_i(a_data),
        .m_valid_i(m_valid), .m_ready_o(m_ready0), .m_addr_i(m_addr), .m_data_i(m_data),
        .wren_o(wren0), .wr_o(wr0), .wd_o(wd0), .init_done_o(init_done0),
        .q1_addr_i(q1_addr), .q2_addr_i(q2_addr), .q1_hit_o(q1_hit0), .q2_hit_o(q2_hit0)
    );

    regfile_write_ctrl #(.CLEAR_ON_RESET(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready1), .a_addr_i(a_addr), .a_data_i(a_data),
        .m_valid_i(m_valid), .m_ready_o(m_ready1), .m_addr_i(m_addr), .m_data_i(m_data),
        .wren_o(wren1), .wr_o(wr1), .wd_o(wd1), .init_done_o(init_done1),
        .q1_addr_i(q1_addr), .q2_addr_i(q2_addr), .q1_hit_o(q1_hit1), .q2_hit_o(q2_hit1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b1;
        m_valid = 1'b1;
        tick();
        tick();
        tests++;
        if (wren0 !== 1'b0 || wr0 !== 5'd0 || wd0 !== 32'd0 || init_done0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got wren=%b wr=%0d wd=%h done=%b exp 0/0/0/0",
                     wren0, wr0, wd0, init_done0);
        end
        tests++;
        if (a_ready0 !== 1'b0 || m_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got a=%b m=%b exp 0/0", a_ready0, m_ready0);
        end
        tests++;
        if (wren1 !== 1'b0 || init_done1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_noclear got wren=%b done=%b exp 0/0", wren1, init_done1);
        end
    endtask

    // Releases reset just after a posedge and checks the full sweep.
    task automatic test_clear();
        a_valid = 1'b1;
        m_valid = 1'b1;
        q2_addr = 5'd0;
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            q1_addr = 5'(k);
            tick();
            tests++;
            if (wren0 !== 1'b1 || wr0 !== 5'(k) || wd0 !== 32'd0) begin
                fails++;
                $display("FAIL clear_write k=%0d got wren=%b wr=%0d wd=%h exp 1/%0d/0",
                         k, wren0, wr0, wd0, k);
            end
            tests++;
            if (init_done0 !== 1'b0 || a_ready0 !== 1'b0 || m_ready0 !== 1'b0) begin
                fails++;
                $display("FAIL clear_state k=%0d got done=%b a=%b m=%b exp 0/0/0",
                         k, init_done0, a_ready0, m_ready0);
            end
            tests++;
            if (q1_hit0 !== 1'b1 || q2_hit0 !== 1'b0) begin
                fails++;
                $display("FAIL clear_hit k=%0d got q1=%b q2=%b exp 1/0", k, q1_hit0, q2_hit0);
            end
        end
        a_valid = 1'b0;
        m_valid = 1'b0;
        tick();
        tests++;
        if (init_done0 !== 1'b1 || wren0 !== 1'b0 || wr0 !== 5'd31) begin
            fails++;
            $display("FAIL clear_exit got done=%b wren=%b wr=%0d exp 1/0/31",
                     init_done0, wren0, wr0);
        end
        tick();
        tests++;
        if (init_done0 !== 1'b1 || wren0 !== 1'b0) begin
            fails++;
            $display("FAIL clear_idle got done=%b wren=%b exp 1/0", init_done0, wren0);
        end
    endtask

    task automatic test_single_alu();
        a_valid = 1'b1;
        a_addr = 5'd5;
        a_data = 32'hDEADBEEF;
        q1_addr = 5'd5;
        q2_addr = 5'd6;
        #1;
        tests++;
        if (a_ready0 !== 1'b1 || m_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL single_ready got a=%b m=%b exp 1/0", a_ready0, m_ready0);
        end
        tick();
        a_valid = 1'b0;
        #1;
        tests++;
        if (wren0 !== 1'b1 || wr0 !== 5'd5 || wd0 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_write got wren=%b wr=%0d wd=%h exp 1/5/deadbeef",
                     wren0, wr0, wd0);
        end
        tests++;
        if (q1_hit0 !== 1'b1 || q2_hit0 !== 1'b0) begin
            fails++;
            $display("FAIL single_hit got q1=%b q2=%b exp 1/0", q1_hit0, q2_hit0);
        end
    endtask

    // prio is 1 here after the ALU grant, so this load grant returns it to 0.
    task automatic test_addr_zero();
        m_valid = 1'b1;
        m_addr = 5'd0;
        m_data = 32'h1234;
        q1_addr = 5'd0;
        #1;
        tests++;
        if (m_ready0 !== 1'b1 || a_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL zero_ready got m=%b a=%b exp 1/0", m_ready0, a_ready0);
        end
        tick();
        m_valid = 1'b0;
        #1;
        tests++;
        if (wren0 !== 1'b0 || wr0 !== 5'd5 || wd0 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL zero_write got wren=%b wr=%0d wd=%h exp 0/5/deadbeef",
                     wren0, wr0, wd0);
        end
        tests++;
        if (q1_hit0 !== 1'b0) begin
            fails++;
            $display("FAIL zero_hit got %b exp 0", q1_hit0);
        end
    endtask

    task automatic test_arbitration();
        logic exp_a;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            m_valid = 1'b1;
            a_addr = 5'(10 + i);
            a_data = 32'hA000_0000 + 32'(i);
            m_addr = 5'(20 + i);
            m_data = 32'hB000_0000 + 32'(i);
            exp_a = ((i % 2) == 0);
            #1;
            tests++;
            if (a_ready0 !== exp_a || m_ready0 !== !exp_a) begin
                fails++;
                $display("FAIL arb_ready i=%0d got a=%b m=%b exp %b/%b",
                         i, a_ready0, m_ready0, exp_a, !exp_a);
            end
            tick();
            tests++;
            if (wren0 !== 1'b1 || wr0 !== (exp_a ? 5'(10 + i) : 5'(20 + i)) ||
                wd0 !== (exp_a ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i))) begin
                fails++;
                $display("FAIL arb_write i=%0d got wren=%b wr=%0d wd=%h", i, wren0, wr0, wd0);
            end
        end
        a_valid = 1'b0;
        m_valid = 1'b0;
    endtask

    // Idle cycle: no write, output registers hold, prio stays 0 so a tie
    // afterwards still goes to the ALU.
    task automatic test_idle();
        tick();
        tests++;
        if (wren0 !== 1'b0 || wr0 !== 5'd23 || wd0 !== 32'hB000_0003) begin
            fails++;
            $display("FAIL idle_hold got wren=%b wr=%0d wd=%h exp 0/23/b0000003",
                     wren0, wr0, wd0);
        end
        a_valid = 1'b1;
        m_valid = 1'b1;
        #1;
        tests++;
        if (a_ready0 !== 1'b1 || m_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL idle_prio got a=%b m=%b exp 1/0", a_ready0, m_ready0);
        end
        a_valid = 1'b0;
        m_valid = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_addr = 5'(1 + i);
            a_data = 32'hC0DE_0000 + 32'(i);
            #1;
            tests++;
            if (a_ready0 !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready i=%0d got %b exp 1", i, a_ready0);
            end
            tick();
            tests++;
            if (wren0 !== 1'b1 || wr0 !== 5'(1 + i) || wd0 !== 32'hC0DE_0000 + 32'(i)) begin
                fails++;
                $display("FAIL b2b_write i=%0d got wren=%b wr=%0d wd=%h", i, wren0, wr0, wd0);
            end
        end
        a_valid = 1'b0;
        tick();
        tests++;
        if (wren0 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain got wren=%b exp 0", wren0);
        end
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        tests++;
        if (wren0 !== 1'b1 || wr0 !== 5'd10) begin
            fails++;
            $display("FAIL midclear_pre got wren=%b wr=%0d exp 1/10", wren0, wr0);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (wren0 !== 1'b0 || wr0 !== 5'd0 || wd0 !== 32'd0 || init_done0 !== 1'b0) begin
            fails++;
            $display("FAIL midclear_async got wren=%b wr=%0d wd=%h done=%b exp 0/0/0/0",
                     wren0, wr0, wd0, init_done0);
        end
        tick();
        test_clear();
    endtask

    task automatic test_no_clear();
        rst = 1'b1;
        a_valid = 1'b1;
        a_addr = 5'd9;
        a_data = 32'h0000_0099;
        q1_addr = 5'd9;
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (a_ready1 !== 1'b1 || init_done1 !== 1'b0 || wren1 !== 1'b0) begin
            fails++;
            $display("FAIL noclear_first got ready=%b done=%b wren=%b exp 1/0/0",
                     a_ready1, init_done1, wren1);
        end
        tick();
        a_valid = 1'b0;
        #1;
        tests++;
        if (wren1 !== 1'b1 || wr1 !== 5'd9 || wd1 !== 32'h99 || init_done1 !== 1'b1) begin
            fails++;
            $display("FAIL noclear_write got wren=%b wr=%0d wd=%h done=%b exp 1/9/99/1",
                     wren1, wr1, wd1, init_done1);
        end
        tests++;
        if (q1_hit1 !== 1'b1) begin
            fails++;
            $display("FAIL noclear_hit got %b exp 1", q1_hit1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        a_valid = 1'b0;
        a_addr = 5'd0;
        a_data = 32'd0;
        m_valid = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        q1_addr = 5'd0;
        q2_addr = 5'd0;

        test_reset();
        test_clear();
        test_single_alu();
        test_addr_zero();
        test_arbitration();
        test_idle();
        test_back_to_back();
        test_reset_mid_clear();
        test_no_clear();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
